pc_predict_unit: RTL and testbench

Parametrised fetch-stage PC unit: holds the architectural fetch PC, predicts the next PC with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, and resolves branches reported by execute. It evaluates the 3-bit condition code against the Z/V/N flags and raises a one-cycle flush on misprediction. It sits between instruction memory addressing and the IF/ID pipeline register, replacing the purely combinational next-PC logic.

---
 rtl/pc_predict_if.sv | 35 +++
 rtl/pc_predict_unit.sv | 123 ++++++++++++
 tb/tb_pc_predict_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_predict_if.sv
// Fetch-PC / branch-resolve bundle between the pipeline and pc_predict_unit.
// The unit sits on the slave side; the pipeline (or a bench) drives the master side.
interface pc_predict_if #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
);
  logic              stall;
  logic              halt;
  logic [PC_W-1:0]   fetch_pc;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              ex_valid;
  logic [1:0]        ex_kind;
  logic [PC_W-1:0]   ex_pc;
  logic [2:0]        ex_ccc;
  logic [2:0]        ex_flags;
  logic [IMM_W-1:0]  ex_imm;
  logic [PC_W-1:0]   ex_breg;
  logic              ex_pred_taken;
  logic [PC_W-1:0]   ex_pred_target;
  logic              flush;
  logic [15:0]       mispredict_cnt;

  modport slave (
    input  stall, halt, ex_valid, ex_kind, ex_pc, ex_ccc, ex_flags, ex_imm,
           ex_breg, ex_pred_taken, ex_pred_target,
    output fetch_pc, pred_taken, pred_target, flush, mispredict_cnt
  );

  modport master (
    output stall, halt, ex_valid, ex_kind, ex_pc, ex_ccc, ex_flags, ex_imm,
           ex_breg, ex_pred_taken, ex_pred_target,
    input  fetch_pc, pred_taken, pred_target, flush, mispredict_cnt
  );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB of 2-bit counters; resolves
// execute-stage branches and redirects fetch on a misprediction.
module pc_predict_unit #(
  parameter int PC_W      = 16,
  parameter int BTB_DEPTH = 8,
  parameter int IMM_W     = 9
) (
  input logic         clk,
  input logic         rst_n,
  pc_predict_if.slave bus
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 1;

  function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] flg);
    logic z, v, n;
    {z, v, n} = flg;
    case (ccc)
      3'b000:  cond_met = ~z;
      3'b001:  cond_met = z;
      3'b010:  cond_met = ~z & ~n;
      3'b011:  cond_met = n;
      3'b100:  cond_met = ~n;
      3'b101:  cond_met = z | n;
      3'b110:  cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
    if (up) sat_ctr = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    sat_ctr = (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  // Instruction offset scaled to bytes, sign-extended to the PC width.
  function automatic logic signed [PC_W-1:0] byte_off(input logic [IMM_W-1:0] imm);
    logic signed [PC_W-1:0] ext;
    ext      = PC_W'($signed(imm));
    byte_off = ext <<< 1;
  endfunction

  logic              r_vld [BTB_DEPTH];
  logic [TAG_W-1:0]  r_tag [BTB_DEPTH];
  logic [PC_W-1:0]   r_tgt [BTB_DEPTH];
  logic [1:0]        r_ctr [BTB_DEPTH];
  logic [PC_W-1:0]   r_fetch_pc;
  logic [15:0]       r_mp_cnt;

  logic [IDX_W-1:0]       w_f_idx, w_e_idx;
  logic [TAG_W-1:0]       w_f_tag, w_e_tag;
  logic                   w_pred_taken, w_e_hit;
  logic [PC_W-1:0]        w_pred_target;
  logic                   w_is_br, w_taken, w_mispredict;
  logic signed [PC_W-1:0] w_off;
  logic [PC_W-1:0]        w_seq, w_rel, w_target, w_actual;

  // Prediction is a pure read of the current entry; writes land at the edge.
  assign w_f_idx       = r_fetch_pc[IDX_W:1];
  assign w_f_tag       = r_fetch_pc[PC_W-1:IDX_W+1];
  assign w_pred_taken  = r_vld[w_f_idx] && (r_tag[w_f_idx] == w_f_tag) && r_ctr[w_f_idx][1];
  assign w_pred_target = w_pred_taken ? r_tgt[w_f_idx] : r_fetch_pc + PC_W'(2);

  assign w_is_br  = bus.ex_valid & bus.ex_kind[1];
  assign w_taken  = w_is_br & cond_met(bus.ex_ccc, bus.ex_flags);
  assign w_seq    = bus.ex_pc + PC_W'(2);
  assign w_off    = byte_off(bus.ex_imm);
  assign w_rel    = w_seq + $unsigned(w_off);
  assign w_target = bus.ex_kind[0] ? bus.ex_breg : w_rel;
  assign w_actual = w_taken ? w_target : w_seq;

  // A non-branch that was predicted taken is a BTB alias and must be undone.
  assign w_mispredict = bus.ex_valid &
    (bus.ex_kind[1] ? ((bus.ex_pred_taken != w_taken) ||
                       (w_taken && (bus.ex_pred_target != w_target)))
                    : bus.ex_pred_taken);

  assign w_e_idx = bus.ex_pc[IDX_W:1];
  assign w_e_tag = bus.ex_pc[PC_W-1:IDX_W+1];
  assign w_e_hit = r_vld[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

  assign bus.fetch_pc       = r_fetch_pc;
  assign bus.pred_taken     = w_pred_taken;
  assign bus.pred_target    = w_pred_target;
  assign bus.flush          = w_mispredict;
  assign bus.mispredict_cnt = r_mp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= '0;
      r_mp_cnt   <= '0;
    end else begin
      if (!bus.halt) begin
        if (w_mispredict)    r_fetch_pc <= w_actual;
        else if (!bus.stall) r_fetch_pc <= w_pred_target;
      end
      if (w_mispredict && (r_mp_cnt != 16'hFFFF)) r_mp_cnt <= r_mp_cnt + 16'd1;
    end
  end

  // Not-taken misses are not allocated, so cold branches never evict entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_ctr[i] <= 2'b01;
      end
    end else if (w_is_br && !bus.halt) begin
      if (w_e_hit) begin
        r_ctr[w_e_idx] <= sat_ctr(r_ctr[w_e_idx], w_taken);
        if (w_taken) r_tgt[w_e_idx] <= w_target;
      end else if (w_taken) begin
        r_vld[w_e_idx] <= 1'b1;
        r_tag[w_e_idx] <= w_e_tag;
        r_tgt[w_e_idx] <= w_target;
        r_ctr[w_e_idx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: directed scenarios then random traffic,
// each cycle's expected outputs come from a table-level model of the unit.
module tb_pc_predict_unit;

  localparam int PC_W = 16;
  localparam int DEPTH = 8;
  localparam int IMM_W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_predict_if #(.PC_W(PC_W), .IMM_W(IMM_W)) bus ();

  pc_predict_unit #(.PC_W(PC_W), .BTB_DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int pc;
    int ptk;
    int ptgt;
    int fl;
    int cnt;
  } exp_t;

  typedef struct {
    bit v;
    int tag;
    int tgt;
    int ctr;
  } ent_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  ent_t m_btb[DEPTH];
  int   m_pc;
  int   m_cnt;

  function automatic int wrap(input int x);
    return ((x % 65536) + 65536) % 65536;
  endfunction

  // Condition table with flags written out as separate Z, V, N bits.
  function automatic bit cond_ok(input int ccc, input bit z, input bit v, input bit n);
    case (ccc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return !n;
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_btb[i] = '{v: 1'b0, tag: 0, tgt: 0, ctr: 1};
    m_pc = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_pred(input int pc, output int ptk, output int ptgt);
    ent_t e;
    e = m_btb[(pc / 2) % DEPTH];
    ptk = (e.v && e.tag == pc / (2 * DEPTH) && e.ctr >= 2) ? 1 : 0;
    ptgt = ptk ? e.tgt : wrap(pc + 2);
  endfunction

  function automatic int branch_target(input int kind, input int pc, input int imm, input int breg);
    int simm;
    simm = (imm >= 256) ? imm - 512 : imm;
    return (kind == 3) ? breg : wrap(pc + 2 + simm * 2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs at the falling edge, queue the expected outputs,
  // then advance the model to the state after the next rising edge.
  task automatic cyc(input bit rst, input bit hlt, input bit stl, input bit ev,
                     input int kind, input int pc, input int ccc, input int flg,
                     input int imm, input int breg, input bit ptk_in, input int ptgt_in);
    int ptk, ptgt, tgt, actual, ei, etag;
    bit br, taken, mp, hit;
    exp_t e;
    @(negedge clk);
    rst_n = rst;
    bus.halt = hlt;
    bus.stall = stl;
    bus.ex_valid = ev;
    bus.ex_kind = kind[1:0];
    bus.ex_pc = pc[15:0];
    bus.ex_ccc = ccc[2:0];
    bus.ex_flags = flg[2:0];
    bus.ex_imm = imm[8:0];
    bus.ex_breg = breg[15:0];
    bus.ex_pred_taken = ptk_in;
    bus.ex_pred_target = ptgt_in[15:0];
    if (!rst) model_reset();
    model_pred(m_pc, ptk, ptgt);
    br = ev && kind >= 2;
    taken = br && cond_ok(ccc, flg[2], flg[1], flg[0]);
    tgt = branch_target(kind, pc, imm, breg);
    actual = taken ? tgt : wrap(pc + 2);
    if (!ev) mp = 0;
    else if (kind >= 2) mp = (ptk_in != taken) || (taken && ptgt_in != tgt);
    else mp = ptk_in;
    e = '{pc: m_pc, ptk: ptk, ptgt: ptgt, fl: mp, cnt: m_cnt};
    q.push_back(e);
    if (rst) begin
      if (br && !hlt) begin
        ei = (pc / 2) % DEPTH;
        etag = pc / (2 * DEPTH);
        hit = m_btb[ei].v && m_btb[ei].tag == etag;
        if (hit) begin
          m_btb[ei].ctr = taken ? (m_btb[ei].ctr == 3 ? 3 : m_btb[ei].ctr + 1)
                                : (m_btb[ei].ctr == 0 ? 0 : m_btb[ei].ctr - 1);
          if (taken) m_btb[ei].tgt = tgt;
        end else if (taken) begin
          m_btb[ei] = '{v: 1'b1, tag: etag, tgt: tgt, ctr: 2};
        end
      end
      if (!hlt) begin
        if (mp) m_pc = actual;
        else if (!stl) m_pc = ptgt;
      end
      if (mp && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("fetch_pc", int'(bus.fetch_pc), e.pc);
        chk("pred_taken", int'(bus.pred_taken), e.ptk);
        chk("pred_target", int'(bus.pred_target), e.ptgt);
        chk("flush", int'(bus.flush), e.fl);
        chk("mispredict_cnt", int'(bus.mispredict_cnt), e.cnt);
      end
    end
  end

  initial begin
    int pc, kind, ccc, flg, imm, breg, ptk, ptgt, tgt, sel;
    bus.halt = 0; bus.stall = 0; bus.ex_valid = 0; bus.ex_kind = 0; bus.ex_pc = 0;
    bus.ex_ccc = 0; bus.ex_flags = 0; bus.ex_imm = 0; bus.ex_breg = 0;
    bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
    model_reset();

    // Reset, then free-running fetch 0,2,4,6,8.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    // Taken EQ branch at 0x10, not predicted: allocate, redirect to 0x1A.
    cyc(1, 0, 0, 1, 2, 'h10, 1, 3'b100, 'h004, 0, 0, 0);
    idle(2);
    // Alias redirect to 0x0010 so the new entry is looked up.
    cyc(1, 0, 0, 1, 0, 'h0E, 0, 0, 0, 0, 1, 'h40);
    idle(1);
    // Correctly predicted resolve: no flush, counter strengthens.
    cyc(1, 0, 0, 1, 2, 'h10, 1, 3'b100, 'h004, 0, 1, 'h1A);
    idle(1);
    // Register branch mispredicted target while stalled.
    cyc(1, 0, 1, 1, 3, 'h200, 7, 0, 0, 'h1234, 1, 'h1000);
    idle(1);
    // Negative offset of one instruction lands back on the branch itself.
    cyc(1, 0, 0, 1, 2, 'h40, 7, 0, 'h1FF, 0, 0, 0);
    idle(1);
    // Condition sweep over every code and flag pattern.
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        cyc(1, 0, 1, 1, 2, 'h300 + 2 * f, c, f, 'h010, 0, 0, 0);
    // Mispredict under halt: fetch holds, BTB entry at 0x10 untouched.
    cyc(1, 1, 0, 1, 2, 'h10, 7, 0, 'h020, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 'h0E, 0, 0, 0, 0, 1, 'h40);
    idle(2);
    // Mid-run reset.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random traffic over a small address pool so entries hit and alias.
    for (int i = 0; i < 1500; i++) begin
      pc = ($urandom_range(0, 15) * 2) + ($urandom_range(0, 1) * 'h100);
      kind = $urandom_range(0, 3);
      ccc = $urandom_range(0, 7);
      flg = $urandom_range(0, 7);
      imm = $urandom_range(0, 511);
      breg = $urandom_range(0, 65535) & 16'hFFFE;
      tgt = branch_target(kind, pc, imm, breg);
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        model_pred(pc, ptk, ptgt);
      end else if (sel == 1) begin
        ptk = 1; ptgt = tgt;
      end else if (sel == 2) begin
        ptk = 0; ptgt = 0;
      end else begin
        ptk = $urandom_range(0, 1); ptgt = $urandom_range(0, 65535);
      end
      if ($urandom_range(0, 299) == 0)
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else
        cyc(1, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) != 0, kind, pc, ccc, flg, imm, breg, ptk, ptgt);
    end

    idle(1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
